// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: demand-driven main/side intersection controller with walk lamp and flashing-yellow override
module traffic_light_ctrl #(
    parameter int unsigned MAIN_GREEN_T = 8,
    parameter int unsigned SIDE_GREEN_T = 4,
    parameter int unsigned YELLOW_T     = 2,
    parameter int unsigned ALL_RED_T    = 1,
    parameter int unsigned FLASH_T      = 2,
    parameter int unsigned TW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flash,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {MG = 3'd0, MY = 3'd1, AR1 = 3'd2, SG = 3'd3, SY = 3'd4, AR2 = 3'd5, FL = 3'd6} state_t;
    localparam logic [TW-1:0] MG_L = TW'(MAIN_GREEN_T - 1);
    localparam logic [TW-1:0] SG_L = TW'(SIDE_GREEN_T - 1);
    localparam logic [TW-1:0] Y_L  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_L = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] FL_L = TW'(FLASH_T - 1);
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          side_pend_q, side_pend_d, ped_pend_q, ped_pend_d;
    logic          walk_q, walk_d, tog_q, tog_d;
    logic          demand;
    assign demand = side_pend_q | ped_pend_q | side_req | ped_req;
    // Next state, dwell timer, request latches, walk flag and flash toggle
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + 1'b1;
        side_pend_d = side_pend_q | side_req;
        ped_pend_d  = ped_pend_q | ped_req;
        walk_d      = walk_q;
        tog_d       = tog_q;
        case (state_q)
            MG: begin
                if (timer_q >= MG_L) timer_d = timer_q;
                if (timer_q >= MG_L && demand) state_d = MY;
            end
            MY:  if (timer_q == Y_L) state_d = AR1;
            AR1: if (timer_q == AR_L) state_d = SG;
            SG:  if (timer_q == SG_L) state_d = SY;
            SY:  if (timer_q == Y_L) state_d = AR2;
            AR2: if (timer_q == AR_L) state_d = MG;
            FL: begin
                if (!flash) state_d = AR2;
                else if (timer_q == FL_L) begin
                    tog_d   = ~tog_q;
                    timer_d = '0;
                end
            end
            default: state_d = MG;
        endcase
        if (flash) state_d = FL;
        if (state_d != state_q) timer_d = '0;
        if (state_d == FL && state_q != FL) tog_d = 1'b0;
        if (state_q == AR1 && state_d == SG) begin
            side_pend_d = side_req;
            ped_pend_d  = ped_req;
            walk_d      = ped_pend_q | ped_req;
        end
        if (state_q == SG && state_d != SG) walk_d = 1'b0;
    end
    // State and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MG;
            timer_q     <= '0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            walk_q      <= 1'b0;
            tog_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            walk_q      <= walk_d;
            tog_q       <= tog_d;
        end
    end
    // Output decode from registered state only
    always_comb begin
        main_light = 2'b00;
        side_light = 2'b00;
        walk       = 1'b0;
        phase      = state_q;
        case (state_q)
            MG: main_light = 2'b01;
            MY: main_light = 2'b10;
            SG: begin
                side_light = 2'b01;
                walk       = walk_q;
            end
            SY: side_light = 2'b10;
            FL: begin
                main_light = tog_q ? 2'b11 : 2'b10;
                side_light = tog_q ? 2'b11 : 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed checks of sequencing, walk, flash and reset behaviour
module tb_traffic_light_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flash = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] main_light, side_light;
    logic       walk;
    logic [2:0] phase;
    int         total = 0;
    int         passed = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl dut (
        .clk(clk), .rst(rst), .flash(flash), .side_req(side_req), .ped_req(ped_req),
        .main_light(main_light), .side_light(side_light), .walk(walk), .phase(phase)
    );

    task automatic chk(input string tag, input int c, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all(input int c, input logic [2:0] ph, input logic [1:0] ml, input logic [1:0] sl, input logic w);
        chk("phase", c, phase, ph);
        chk("main_light", c, {1'b0, main_light}, {1'b0, ml});
        chk("side_light", c, {1'b0, side_light}, {1'b0, sl});
        chk("walk", c, {2'b00, walk}, {2'b00, w});
    endtask

    function automatic logic [3:0] heads(input logic [2:0] ph);
        case (ph)
            3'd0: heads = 4'b0100;
            3'd1: heads = 4'b1000;
            3'd3: heads = 4'b0001;
            3'd4: heads = 4'b0010;
            default: heads = 4'b0000;
        endcase
    endfunction

    task automatic chk_ph(input int c, input logic [2:0] ph, input logic w);
        logic [3:0] hd;
        hd = heads(ph);
        chk_all(c, ph, hd[3:2], hd[1:0], w);
    endtask

    function automatic logic [2:0] sched(input int c);
        if (c < 8) sched = 3'd0;
        else if (c < 10) sched = 3'd1;
        else if (c == 10) sched = 3'd2;
        else if (c < 15) sched = 3'd3;
        else if (c < 17) sched = 3'd4;
        else if (c == 17) sched = 3'd5;
        else sched = 3'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_ph(-1, 3'd0, 1'b0);
        // idle: no demand keeps main green
        rel();
        for (int c = 0; c < 50; c++) begin
            chk_ph(c, 3'd0, 1'b0);
            step();
        end
        // side_req held: full default sequence
        rst = 1'b1;
        rel();
        side_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk_ph(c, sched(c), 1'b0);
            step();
        end
        // ped pulse in MG: walk during SG only, then rest in MG
        side_req = 1'b0;
        rst = 1'b1;
        rel();
        for (int c = 0; c < 30; c++) begin
            ped_req = (c == 3);
            chk_ph(c, c < 18 ? sched(c) : 3'd0, c >= 11 && c <= 14);
            step();
        end
        // ped pulse during SG: served in next SG after a full minimum green
        rst = 1'b1;
        rel();
        for (int c = 0; c < 56; c++) begin
            side_req = (c == 0);
            ped_req = (c == 12);
            chk_ph(c, c < 18 ? sched(c) : c < 36 ? sched(c - 18) : 3'd0, c >= 29 && c <= 32);
            step();
        end
        // flash override from MY, then AR2 and MG
        rst = 1'b1;
        rel();
        for (int c = 0; c < 26; c++) begin
            side_req = (c < 3);
            flash = (c >= 9 && c <= 14);
            if (c >= 10 && c <= 15) chk_all(c, 3'd6, (c == 12 || c == 13) ? 2'b11 : 2'b10, (c == 12 || c == 13) ? 2'b11 : 2'b10, 1'b0);
            else if (c == 16) chk_ph(c, 3'd5, 1'b0);
            else if (c == 25) chk_ph(c, 3'd1, 1'b0);
            else chk_ph(c, c < 10 ? sched(c) : 3'd0, 1'b0);
            step();
        end
        // asynchronous reset mid-SG drops pending demand
        rst = 1'b1;
        rel();
        side_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk_ph(c, sched(c), 1'b0);
            step();
        end
        chk_ph(12, 3'd3, 1'b0);
        #2 rst = 1'b1;
        #1 chk_ph(-2, 3'd0, 1'b0);
        side_req = 1'b0;
        rel();
        for (int c = 0; c < 12; c++) begin
            chk_ph(c, 3'd0, 1'b0);
            step();
        end
        side_req = 1'b1;
        chk_ph(12, 3'd0, 1'b0);
        step();
        chk_ph(13, 3'd1, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-approach intersection controller: a main road and a side road, each with its own signal head, plus a pedestrian walk output. Dwell times are set by parameters. The block is demand-driven: main green rests until a side-road or pedestrian request arrives. A flashing-yellow override is available for fault or maintenance use. It is the generalised successor of the fixed three-state light sequencer and uses the same 2-bit light encoding, extended with OFF.

## Interface
- `MAIN_GREEN_T`, default 8: minimum main-green cycles.
- `SIDE_GREEN_T`, default 4: side-green cycles (fixed).
- `YELLOW_T`, default 2: yellow cycles, both approaches.
- `ALL_RED_T`, default 1: all-red clearance cycles.
- `FLASH_T`, default 2: half-period of flash, in cycles.
- `TW`, default 8: timer width. Every duration must be in the range 1..2^TW.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, asynchronous, active-high.
- `flash` input 1: level; flashing-yellow override request.
- `side_req` input 1: side-road vehicle detector (pulse or level).
- `ped_req` input 1: pedestrian button (pulse or level).
- `main_light` output 2: main head. 00 RED, 01 GREEN, 10 YELLOW, 11 OFF.
- `side_light` output 2: side head, same encoding.
- `walk` output 1: pedestrian walk lamp.
- `phase` output 3: current state code, for debug.

## Operation
States and `phase` codes:
- 0 MG: main green, side red.
- 1 MY: main yellow, side red.
- 2 AR1: all red.
- 3 SG: main red, side green.
- 4 SY: main red, side yellow.
- 5 AR2: all red.
- 6 FL: flash.

Outputs are a pure decode of the state register and the flash toggle bit. There is no combinational path from inputs to outputs.

Timer:
- One TW-bit up-counter.
- Cleared to 0 on every state change.
- Otherwise increments each cycle.
- In MG it saturates at MAIN_GREEN_T-1.

Request latches:
- `side_pend` sets when `side_req`=1; `ped_pend` sets when `ped_req`=1.
- Both latches clear on the AR1→SG transition.
- A request asserted on the clearing edge wins: the latch stays set and is served next cycle.
- Demand = side_pend | ped_pend | side_req | ped_req.

Transitions:
- MG→MY when timer ≥ MAIN_GREEN_T-1 and demand=1. Otherwise MG holds indefinitely.
- MY→AR1 after YELLOW_T cycles in MY.
- AR1→SG after ALL_RED_T cycles in AR1.
- SG→SY after SIDE_GREEN_T cycles in SG.
- SY→AR2 after YELLOW_T cycles in SY.
- AR2→MG after ALL_RED_T cycles in AR2.
- Any state→FL on the next edge when `flash`=1. This has priority over every other transition.
- FL→AR2 on the first edge with `flash`=0. AR2 then runs its full ALL_RED_T cycles before MG.

Walk:
- On AR1→SG, a walk flag loads the value of ped_pend | ped_req.
- `walk` = flag while in SG, and 0 in every other state.
- The flag clears on leaving SG.

Flash:
- A toggle bit resets to 0 on entry to FL and inverts every FLASH_T cycles.
- While in FL, both heads show YELLOW when the toggle is 0 and OFF when it is 1.

## Timing
Reset values (asynchronous, immediate on `rst`=1):
- Outputs: state MG, `main_light`=01, `side_light`=00, `walk`=0, `phase`=0.
- Internal: timer 0, both request latches 0, walk flag 0, flash toggle 0.

Cycle numbering: cycle 0 is the first rising edge after `rst` deasserts. State k is visible during cycle k.

Default sequence with `side_req` held at 1 from cycle 0:
- MG: cycles 0–7.
- MY: cycles 8–9.
- AR1: cycle 10.
- SG: cycles 11–14.
- SY: cycles 15–16.
- AR2: cycle 17.
- MG again: from cycle 18.

Boundary rules:
- Dwell in each timed state is exactly its parameter.
- The minimum main green holds even if demand arrives at cycle 0.
- A duration of 1 gives single-cycle states. The timer never wraps.
- Requests arriving during MY, AR1 or SG are latched, apart from the AR1→SG edge. The AR1→SG edge clears the latches and loads the walk flag, so a request on that edge is captured and also kept pending (set-wins). Requests in SY or AR2 are also latched. All latched requests are served in the next cycle.
- `flash` deasserting and reasserting within FL has no effect until the edge on which it is seen low.
- Reset mid-cycle returns the block to MG with the timer at 0. Pending requests are lost.

## Test plan
- No demand for 50 cycles after reset → MG throughout; `main_light`=01, `side_light`=00, `phase`=0.
- `side_req` held at 1 → phase sequence 0 (×8), 1 (×2), 2, 3 (×4), 4 (×2), 5, 0 at the cycle numbers listed above; `walk` stays 0.
- Single-cycle `ped_req` pulse at cycle 3 → MY starts at cycle 8; `walk`=1 during cycles 11–14 only; ped_pend is clear afterwards.
- `ped_req` pulse during SG at cycle 12 → no walk in the current SG; the next MG runs its 8-cycle minimum, then a full cycle with `walk`=1 in that SG.
- `flash` high at cycle 9 (during MY) → FL from cycle 10; both heads read 10,10,11,11,10… with changes every 2 cycles. Drop `flash` → one AR2 cycle (both heads 00), then MG.
- `rst` pulsed mid-SG, asynchronous and between edges → outputs go to their reset values immediately; after release the block runs a fresh 8-cycle MG with no pending demand.
